// File: rtl/mealy_seq_pkg.sv
// mealy_seq_pkg: constant helpers that derive KMP next-state values for the serial pattern detector.
//   seq_state_w(len)              -> width of the state register for a len-bit pattern
//   seq_next(pattern,len,s,b)     -> leading pattern bits still matched after bit b arrives in state s
//   seq_border(pattern,len)       -> longest proper border of the full pattern (overlap restart)
package mealy_seq_pkg;

   localparam int SEQ_MAX_LEN = 16;

   function automatic int seq_state_w(input int len);
      return $clog2(len);
   endfunction

   // History is the first s pattern bits followed by b; the result is the longest k < len
   // whose last k history bits equal the first k pattern bits (bit [len-1] is first).
   function automatic int seq_next(input logic [SEQ_MAX_LEN-1:0] pattern, input int len,
                                   input int s, input logic b);
      int   r;
      int   i;
      logic ok;
      logic h;
      r = 0;
      for (int k = 1; k < len; k++) begin
         if (k <= s + 1) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
               i = s + 1 - k + j;
               h = (i < s) ? pattern[len-1-i] : b;
               if (h != pattern[len-1-j]) ok = 1'b0;
            end
            if (ok) r = k;
         end
      end
      return r;
   endfunction

   // Feeding the final bit from the last state leaves exactly the longest proper border.
   function automatic int seq_border(input logic [SEQ_MAX_LEN-1:0] pattern, input int len);
      return seq_next(pattern, len, len - 1, pattern[0]);
   endfunction

endpackage

// File: rtl/seq_match_counter.sv
// seq_match_counter: saturating event counter with synchronous clear taking priority over increment.
//   clk, rst (async, active-high) | inc: count one event | clr: zero at next edge | cnt: current count
module seq_match_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;

   assign cnt = cnt_q;

endmodule

// File: rtl/mealy_seq_detector.sv
// mealy_seq_detector: parametrised Mealy detector for a PAT_LEN-bit serial pattern with a match counter.
//   clk, rst (async, active-high) | en: x is consumed only when high | x: serial bit
//   clr_cnt: sync clear of match_cnt | y: combinational match flag | match_cnt: saturating matches
//   state_o: number of leading pattern bits currently matched
module mealy_seq_detector
   import mealy_seq_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            x,
   input  logic                            clr_cnt,
   output logic                            y,
   output logic [CNT_W-1:0]                match_cnt,
   output logic [seq_state_w(PAT_LEN)-1:0] state_o
);

   localparam int             SW      = seq_state_w(PAT_LEN);
   localparam int             NS      = 1 << SW;
   localparam logic [SW-1:0]  LAST    = SW'(PAT_LEN - 1);
   localparam logic [SW-1:0]  RESTART = OVERLAP ? SW'(seq_border(16'(PATTERN), PAT_LEN)) : '0;

   logic [SW-1:0] state_q, state_d;
   logic [SW-1:0] next_tbl [NS][2];

   if (PAT_LEN < 2 || PAT_LEN > SEQ_MAX_LEN) begin : g_bad_len
      $error("mealy_seq_detector: PAT_LEN must be in 2..16");
   end

   // Table covers every encoding so unreachable states fall back to 0 without a range check.
   for (genvar s = 0; s < NS; s++) begin : g_s
      for (genvar b = 0; b < 2; b++) begin : g_b
         if (s < PAT_LEN) begin : g_v
            assign next_tbl[s][b] = SW'(seq_next(16'(PATTERN), PAT_LEN, s, 1'(b)));
         end else begin : g_z
            assign next_tbl[s][b] = '0;
         end
      end
   end

   always_comb begin
      y       = en & ~rst & (state_q == LAST) & (x == PATTERN[0]);
      state_d = ~en ? state_q : y ? RESTART : next_tbl[state_q][x];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= '0;
      else     state_q <= state_d;

   assign state_o = state_q;

   seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (y),
      .clr (clr_cnt),
      .cnt (match_cnt)
   );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// tb_mealy_seq_detector: directed checks of the 1011 detector in overlap, non-overlap and 2-bit counter builds.
module tb_mealy_seq_detector;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic       x   = 1'b0;
   logic       clr = 1'b0;
   logic       y0, y1, y2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;
   logic [1:0] st0, st1, st2;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
      .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr), .y(y0), .match_cnt(cnt0), .state_o(st0));
   mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
      .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr), .y(y1), .match_cnt(cnt1), .state_o(st1));
   mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr), .y(y2), .match_cnt(cnt2), .state_o(st2));

   task automatic drive(input logic xv, input logic ev);
      @(negedge clk);
      x  = xv;
      en = ev;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      @(negedge clk);
      rst = 1'b1; en = 1'b0; x = 1'b0; clr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      en = 1'b1; x = 1'b1; clr = 1'b0;
      #2 rst = 1'b1;
      #1;
      tests++; if (st0 !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", st0); end
      tests++; if (cnt0 !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", cnt0); end
      tests++; if (y0 !== 1'b0) begin fails++; $display("FAIL reset_y got %b exp 0", y0); end
      tick;
      tests++; if (st2 !== 2'd0) begin fails++; $display("FAIL reset_hold_state got %0d exp 0", st2); end
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
   endtask

   task automatic test_overlap;
      logic [6:0] bits = 7'b1011011;
      logic [6:0] ey_ov = 7'b0001001;
      logic [6:0] ey_no = 7'b0001000;
      logic [1:0] so [7] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
      logic [1:0] sn [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
      apply_reset;
      for (int i = 0; i < 7; i++) begin
         drive(bits[6-i], 1'b1);
         tests++; if (y0 !== ey_ov[6-i]) begin fails++; $display("FAIL ov_y[%0d] got %b exp %b", i, y0, ey_ov[6-i]); end
         tests++; if (y1 !== ey_no[6-i]) begin fails++; $display("FAIL no_y[%0d] got %b exp %b", i, y1, ey_no[6-i]); end
         tick;
         tests++; if (st0 !== so[i]) begin fails++; $display("FAIL ov_state[%0d] got %0d exp %0d", i, st0, so[i]); end
         tests++; if (st1 !== sn[i]) begin fails++; $display("FAIL no_state[%0d] got %0d exp %0d", i, st1, sn[i]); end
      end
      tests++; if (cnt0 !== 8'd2) begin fails++; $display("FAIL ov_cnt got %0d exp 2", cnt0); end
      tests++; if (cnt1 !== 8'd1) begin fails++; $display("FAIL no_cnt got %0d exp 1", cnt1); end
   endtask

   task automatic test_fallback;
      logic [5:0] bits = 6'b101011;
      logic [5:0] ey = 6'b000001;
      logic [1:0] st [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1};
      apply_reset;
      for (int i = 0; i < 6; i++) begin
         drive(bits[5-i], 1'b1);
         tests++; if (y0 !== ey[5-i]) begin fails++; $display("FAIL fb_y[%0d] got %b exp %b", i, y0, ey[5-i]); end
         tick;
         tests++; if (st0 !== st[i]) begin fails++; $display("FAIL fb_state[%0d] got %0d exp %0d", i, st0, st[i]); end
      end
   endtask

   task automatic test_enable;
      apply_reset;
      drive(1'b1, 1'b1); tick;
      drive(1'b0, 1'b1); tick;
      drive(1'b1, 1'b1); tick;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0);
         tests++; if (y0 !== 1'b0) begin fails++; $display("FAIL en_y[%0d] got %b exp 0", i, y0); end
         tick;
         tests++; if (st0 !== 2'd3) begin fails++; $display("FAIL en_state[%0d] got %0d exp 3", i, st0); end
      end
      drive(1'b1, 1'b0);
      tests++; if (y0 !== 1'b0) begin fails++; $display("FAIL en_low_match_y got %b exp 0", y0); end
      drive(1'b1, 1'b1);
      tests++; if (y0 !== 1'b1) begin fails++; $display("FAIL en_resume_y got %b exp 1", y0); end
      tick;
      tests++; if (cnt0 !== 8'd1) begin fails++; $display("FAIL en_cnt got %0d exp 1", cnt0); end
      tests++; if (st0 !== 2'd1) begin fails++; $display("FAIL en_resume_state got %0d exp 1", st0); end
   endtask

   task automatic test_async_reset;
      apply_reset;
      drive(1'b1, 1'b1); tick;
      drive(1'b0, 1'b1); tick;
      drive(1'b1, 1'b1); tick;
      tests++; if (st0 !== 2'd3) begin fails++; $display("FAIL ar_pre_state got %0d exp 3", st0); end
      drive(1'b1, 1'b1);
      tests++; if (y0 !== 1'b1) begin fails++; $display("FAIL ar_pre_y got %b exp 1", y0); end
      #2 rst = 1'b1;
      #1;
      tests++; if (st0 !== 2'd0) begin fails++; $display("FAIL ar_state got %0d exp 0", st0); end
      tests++; if (y0 !== 1'b0) begin fails++; $display("FAIL ar_y got %b exp 0", y0); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++; if (y0 !== 1'b0) begin fails++; $display("FAIL ar_after_y got %b exp 0", y0); end
      tick;
      tests++; if (st0 !== 2'd1) begin fails++; $display("FAIL ar_after_state got %0d exp 1", st0); end
      tests++; if (cnt0 !== 8'd0) begin fails++; $display("FAIL ar_cnt got %0d exp 0", cnt0); end
   endtask

   task automatic test_saturation;
      logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      apply_reset;
      drive(1'b1, 1'b1); tick;
      drive(1'b0, 1'b1); tick;
      drive(1'b1, 1'b1); tick;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 1'b1);
         tests++; if (y2 !== 1'b1) begin fails++; $display("FAIL sat_y[%0d] got %b exp 1", k, y2); end
         tick;
         tests++; if (cnt2 !== ec[k]) begin fails++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", k, cnt2, ec[k]); end
         tests++; if (cnt0 !== 8'(k + 1)) begin fails++; $display("FAIL wide_cnt[%0d] got %0d exp %0d", k, cnt0, k + 1); end
         drive(1'b0, 1'b1); tick;
         drive(1'b1, 1'b1); tick;
      end
      drive(1'b1, 1'b1);
      clr = 1'b1;
      #1;
      tests++; if (y2 !== 1'b1) begin fails++; $display("FAIL clr_y got %b exp 1", y2); end
      tick;
      clr = 1'b0;
      tests++; if (cnt2 !== 2'd0) begin fails++; $display("FAIL clr_cnt got %0d exp 0", cnt2); end
      tests++; if (cnt0 !== 8'd0) begin fails++; $display("FAIL clr_wide_cnt got %0d exp 0", cnt0); end
      tests++; if (st2 !== 2'd1) begin fails++; $display("FAIL clr_state got %0d exp 1", st2); end
      drive(1'b0, 1'b1); tick;
      drive(1'b1, 1'b1); tick;
      drive(1'b1, 1'b1); tick;
      tests++; if (cnt2 !== 2'd1) begin fails++; $display("FAIL clr_recount got %0d exp 1", cnt2); end
   endtask

   initial begin
      test_reset;
      test_overlap;
      test_fallback;
      test_enable;
      test_async_reset;
      test_saturation;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
